// File: rtl/alu_if.sv
// alu_if: request/response bundle between the operand path and the execute-stage ALU.
interface alu_if #(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              alusrc;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [IMM_W-1:0]  imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] opb_mux;
    logic              zero;
    logic              overflow;
    logic              illegal_op;
    modport master (
        output in_valid, alusrc, alu_op, read_data1, read_data2, imm, out_ready,
        input  in_ready, out_valid, alu_result, imm_sext, opb_mux, zero, overflow, illegal_op
    );
    modport slave (
        input  in_valid, alusrc, alu_op, read_data1, read_data2, imm, out_ready,
        output in_ready, out_valid, alu_result, imm_sext, opb_mux, zero, overflow, illegal_op
    );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked execute-stage ALU with iterative shifts.
// Define ALU_MULT_EN to add the shift-add multiply (op 1011); otherwise 1011 is illegal.
module alu_multicycle #(
    parameter int DATA_W = 8,
    parameter int IMM_W  = 3
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    localparam int SHW = $clog2(DATA_W);
    localparam int CW  = SHW + 1;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
`ifdef ALU_MULT_EN
    localparam logic [3:0] OP_MUL = 4'b1011;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef ALU_MULT_EN
        MUL,
`endif
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] w_q, w_d, res_q, res_d, imm_q, imm_d, opb_q, opb_d;
    logic              zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
`ifdef ALU_MULT_EN
    logic [2*DATA_W-1:0] prod_q, prod_d, mc_q, mc_d, prod_nx;
    logic [DATA_W-1:0]   mp_q, mp_d;
`endif

    logic [DATA_W-1:0] imm_x, opb, a, add, sub, sc_r, step;
    logic [SHW-1:0]    amt;
    logic              sc_ov, sc_ill, is_shift, add_ov, sub_ov;

    assign imm_x    = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    assign opb      = bus.alusrc ? imm_x : bus.read_data2;
    assign a        = bus.read_data1;
    assign amt      = opb[SHW-1:0];
    assign add      = a + opb;
    assign sub      = a - opb;
    assign add_ov   = (a[DATA_W-1] == opb[DATA_W-1]) && (add[DATA_W-1] != a[DATA_W-1]);
    assign sub_ov   = (a[DATA_W-1] != opb[DATA_W-1]) && (sub[DATA_W-1] != a[DATA_W-1]);
    assign is_shift = (bus.alu_op == OP_SLL) || (bus.alu_op == OP_SRL) || (bus.alu_op == OP_SRA);
    assign step     = op_q == OP_SLL ? w_q << 1 :
                      op_q == OP_SRL ? w_q >> 1 : {w_q[DATA_W-1], w_q[DATA_W-1:1]};
`ifdef ALU_MULT_EN
    assign prod_nx  = mp_q[0] ? prod_q + mc_q : prod_q;
`endif

    always_comb begin
        sc_r   = '0;
        sc_ov  = 1'b0;
        sc_ill = 1'b0;
        case (bus.alu_op)
            4'b0000, 4'b0100, 4'b0101, 4'b0110: begin
                sc_r  = add;
                sc_ov = add_ov;
            end
            4'b0001: begin
                sc_r  = sub;
                sc_ov = sub_ov;
            end
            4'b0010: sc_r = a & opb;
            4'b0011: sc_r = a | opb;
            OP_SLL, OP_SRL, OP_SRA: sc_r = a;
            4'b1010: sc_r = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(opb)};
`ifdef ALU_MULT_EN
            OP_MUL: sc_r = '0;
`endif
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        res_d   = res_q;
        imm_d   = imm_q;
        opb_d   = opb_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
`ifdef ALU_MULT_EN
        prod_d  = prod_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                op_d    = bus.alu_op;
                imm_d   = imm_x;
                opb_d   = opb;
                w_d     = a;
                cnt_d   = {1'b0, amt};
                state_d = (is_shift && amt != '0) ? SHIFT : DONE;
`ifdef ALU_MULT_EN
                if (bus.alu_op == OP_MUL) begin
                    prod_d  = '0;
                    mc_d    = {{DATA_W{1'b0}}, a};
                    mp_d    = opb;
                    cnt_d   = CW'(DATA_W);
                    state_d = MUL;
                end
`endif
                // Result and flags only change when the result becomes valid
                if (state_d == DONE) begin
                    res_d  = sc_r;
                    zero_d = sc_r == '0;
                    ovf_d  = sc_ov;
                    ill_d  = sc_ill;
                end
            end
            SHIFT: begin
                w_d   = step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = step;
                    zero_d  = step == '0;
                    ovf_d   = 1'b0;
                    ill_d   = 1'b0;
                end
            end
`ifdef ALU_MULT_EN
            MUL: begin
                prod_d = prod_nx;
                mc_d   = mc_q << 1;
                mp_d   = mp_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    res_d   = prod_nx[DATA_W-1:0];
                    zero_d  = prod_nx[DATA_W-1:0] == '0;
                    ovf_d   = |prod_nx[2*DATA_W-1:DATA_W];
                    ill_d   = 1'b0;
                end
            end
`endif
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            res_q   <= '0;
            imm_q   <= '0;
            opb_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ALU_MULT_EN
            prod_q  <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            res_q   <= res_d;
            imm_q   <= imm_d;
            opb_q   <= opb_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
`ifdef ALU_MULT_EN
            prod_q  <= prod_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
`endif
        end
    end

    assign bus.in_ready   = state_q == IDLE;
    assign bus.out_valid  = state_q == DONE;
    assign bus.alu_result = res_q;
    assign bus.imm_sext   = imm_q;
    assign bus.opb_mux    = opb_q;
    assign bus.zero       = zero_q;
    assign bus.overflow   = ovf_q;
    assign bus.illegal_op = ill_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed-vector bench for alu_multicycle (DATA_W=8, IMM_W=3).
// Expectations for op 1011 follow ALU_MULT_EN.
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_if #(.DATA_W(8), .IMM_W(3)) bus ();
    alu_multicycle #(.DATA_W(8), .IMM_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Drive one request, drop in_valid after the accept edge, return cycles until out_valid
    task automatic run(input logic [3:0] op, input logic src, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] im, output int lat);
        @(negedge clk);
        bus.alu_op = op; bus.alusrc = src; bus.read_data1 = a; bus.read_data2 = b; bus.imm = im;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
        n_chk++; if ({bus.alu_result, bus.imm_sext, bus.opb_mux} !== 24'h0) begin n_fail++; $display("FAIL rst_data got %h exp 000000", {bus.alu_result, bus.imm_sext, bus.opb_mux}); end
        n_chk++; if ({bus.zero, bus.overflow, bus.illegal_op} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b exp 000", {bus.zero, bus.overflow, bus.illegal_op}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_add();
        int lat;
        run(4'b0000, 1'b0, 8'h05, 8'h08, 3'b000, lat);
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency got %0d exp 1", lat); end
        n_chk++; if (bus.alu_result !== 8'h0D) begin n_fail++; $display("FAIL add_result got %h exp 0d", bus.alu_result); end
        n_chk++; if ({bus.zero, bus.overflow} !== 2'b00) begin n_fail++; $display("FAIL add_flags got %b exp 00", {bus.zero, bus.overflow}); end
        n_chk++; if (bus.opb_mux !== 8'h08) begin n_fail++; $display("FAIL add_opb got %h exp 08", bus.opb_mux); end
        take();
        run(4'b0000, 1'b0, 8'h7F, 8'h01, 3'b000, lat);
        n_chk++; if ({bus.alu_result, bus.overflow} !== {8'h80, 1'b1}) begin n_fail++; $display("FAIL add_ovf got %h/%b exp 80/1", bus.alu_result, bus.overflow); end
        take();
    endtask

    task automatic test_shift();
        int lat;
        run(4'b0111, 1'b1, 8'h29, 8'h00, 3'b001, lat);
        n_chk++; if (bus.imm_sext !== 8'h01) begin n_fail++; $display("FAIL sll1_imm got %h exp 01", bus.imm_sext); end
        n_chk++; if (bus.alu_result !== 8'h52) begin n_fail++; $display("FAIL sll1_result got %h exp 52", bus.alu_result); end
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL sll1_latency got %0d exp 2", lat); end
        take();
        run(4'b0111, 1'b0, 8'h01, 8'h07, 3'b000, lat);
        n_chk++; if (bus.alu_result !== 8'h80) begin n_fail++; $display("FAIL sll7_result got %h exp 80", bus.alu_result); end
        n_chk++; if (lat !== 8) begin n_fail++; $display("FAIL sll7_latency got %0d exp 8", lat); end
        take();
        run(4'b1001, 1'b0, 8'h80, 8'h03, 3'b000, lat);
        n_chk++; if ({bus.alu_result, bus.zero} !== {8'hF0, 1'b0}) begin n_fail++; $display("FAIL sra_result got %h/%b exp f0/0", bus.alu_result, bus.zero); end
        n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL sra_latency got %0d exp 4", lat); end
        take();
        run(4'b1000, 1'b0, 8'hA5, 8'h08, 3'b000, lat);
        n_chk++; if ({bus.alu_result, 8'(lat)} !== {8'hA5, 8'd1}) begin n_fail++; $display("FAIL srl0_result got %h lat %0d exp a5 lat 1", bus.alu_result, lat); end
        take();
        run(4'b1000, 1'b0, 8'h81, 8'h02, 3'b000, lat);
        n_chk++; if (bus.alu_result !== 8'h20) begin n_fail++; $display("FAIL srl2_result got %h exp 20", bus.alu_result); end
        take();
    endtask

    task automatic test_arith();
        int lat;
        run(4'b0100, 1'b1, 8'h04, 8'h55, 3'b110, lat);
        n_chk++; if (bus.imm_sext !== 8'hFE) begin n_fail++; $display("FAIL addi_imm got %h exp fe", bus.imm_sext); end
        n_chk++; if ({bus.alu_result, bus.overflow} !== {8'h02, 1'b0}) begin n_fail++; $display("FAIL addi_result got %h/%b exp 02/0", bus.alu_result, bus.overflow); end
        n_chk++; if (bus.opb_mux !== 8'hFE) begin n_fail++; $display("FAIL addi_opb got %h exp fe", bus.opb_mux); end
        take();
        run(4'b0001, 1'b0, 8'h80, 8'h01, 3'b000, lat);
        n_chk++; if ({bus.alu_result, bus.overflow} !== {8'h7F, 1'b1}) begin n_fail++; $display("FAIL sub_ovf got %h/%b exp 7f/1", bus.alu_result, bus.overflow); end
        take();
        run(4'b0001, 1'b0, 8'h05, 8'h05, 3'b000, lat);
        n_chk++; if ({bus.alu_result, bus.zero} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL sub_zero got %h/%b exp 00/1", bus.alu_result, bus.zero); end
        take();
        run(4'b1010, 1'b0, 8'hFF, 8'h01, 3'b000, lat);
        n_chk++; if (bus.alu_result !== 8'h01) begin n_fail++; $display("FAIL slt_result got %h exp 01", bus.alu_result); end
        take();
        run(4'b0010, 1'b0, 8'hF0, 8'h3C, 3'b000, lat);
        n_chk++; if (bus.alu_result !== 8'h30) begin n_fail++; $display("FAIL and_result got %h exp 30", bus.alu_result); end
        take();
        run(4'b0011, 1'b0, 8'hF0, 8'h0C, 3'b000, lat);
        n_chk++; if (bus.alu_result !== 8'hFC) begin n_fail++; $display("FAIL or_result got %h exp fc", bus.alu_result); end
        take();
    endtask

    task automatic test_backpressure();
        int lat;
        run(4'b0000, 1'b0, 8'h10, 8'h20, 3'b000, lat);
        bus.alu_op = 4'b0011; bus.read_data1 = 8'hFF; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if ({bus.out_valid, bus.in_ready, bus.alu_result} !== {1'b1, 1'b0, 8'h30}) begin n_fail++; $display("FAIL bp_hold%0d got v%b r%b %h exp v1 r0 30", i, bus.out_valid, bus.in_ready, bus.alu_result); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_chk++; if ({bus.in_ready, bus.out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release got r%b v%b exp r1 v0", bus.in_ready, bus.out_valid); end
        n_chk++; if (bus.alu_result !== 8'h30) begin n_fail++; $display("FAIL bp_ignored got %h exp 30", bus.alu_result); end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        bus.alu_op = 4'b0111; bus.alusrc = 1'b0; bus.read_data1 = 8'h01; bus.read_data2 = 8'h07;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if ({bus.out_valid, bus.in_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_busy got v%b r%b exp v0 r0", bus.out_valid, bus.in_ready); end
        rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.out_valid, bus.alu_result, bus.imm_sext, bus.opb_mux} !== 25'h0) begin n_fail++; $display("FAIL mid_rst_data got v%b %h %h %h exp all 0", bus.out_valid, bus.alu_result, bus.imm_sext, bus.opb_mux); end
        n_chk++; if ({bus.zero, bus.overflow, bus.illegal_op} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_flags got %b exp 000", {bus.zero, bus.overflow, bus.illegal_op}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b exp 1", bus.in_ready); end
        run(4'b0000, 1'b0, 8'h01, 8'h01, 3'b000, lat);
        n_chk++; if ({bus.alu_result, 8'(lat)} !== {8'h02, 8'd1}) begin n_fail++; $display("FAIL mid_add got %h lat %0d exp 02 lat 1", bus.alu_result, lat); end
        take();
    endtask

    task automatic test_mul_illegal();
        int lat;
        run(4'b1011, 1'b0, 8'h0F, 8'h11, 3'b000, lat);
`ifdef ALU_MULT_EN
        n_chk++; if ({bus.alu_result, bus.overflow, bus.illegal_op} !== {8'hFF, 2'b00}) begin n_fail++; $display("FAIL mul1_result got %h o%b i%b exp ff o0 i0", bus.alu_result, bus.overflow, bus.illegal_op); end
        n_chk++; if (lat !== 9) begin n_fail++; $display("FAIL mul1_latency got %0d exp 9", lat); end
        take();
        run(4'b1011, 1'b0, 8'h10, 8'h10, 3'b000, lat);
        n_chk++; if ({bus.alu_result, bus.overflow, bus.zero} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL mul2_result got %h o%b z%b exp 00 o1 z1", bus.alu_result, bus.overflow, bus.zero); end
`else
        n_chk++; if ({bus.alu_result, bus.illegal_op} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL op1011_illegal got %h i%b exp 00 i1", bus.alu_result, bus.illegal_op); end
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL op1011_latency got %0d exp 1", lat); end
`endif
        take();
        run(4'b1100, 1'b0, 8'h33, 8'h44, 3'b000, lat);
        n_chk++; if ({bus.alu_result, bus.illegal_op, bus.overflow, 8'(lat)} !== {8'h00, 2'b10, 8'd1}) begin n_fail++; $display("FAIL illegal got %h i%b o%b lat %0d exp 00 i1 o0 lat 1", bus.alu_result, bus.illegal_op, bus.overflow, lat); end
        take();
        run(4'b0000, 1'b0, 8'h02, 8'h03, 3'b000, lat);
        n_chk++; if ({bus.alu_result, bus.illegal_op} !== {8'h05, 1'b0}) begin n_fail++; $display("FAIL illegal_clear got %h i%b exp 05 i0", bus.alu_result, bus.illegal_op); end
        take();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.alusrc = 1'b0; bus.alu_op = '0; bus.read_data1 = '0;
        bus.read_data2 = '0; bus.imm = '0; bus.out_ready = 1'b0;
        test_reset();
        test_add();
        test_shift();
        test_arith();
        test_backpressure();
        test_reset_mid();
        test_mul_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
